// File: rtl/frame_buffer_reader.sv
// Custom-instruction controlled burst-read master that streams a frame buffer
// out of memory through a 32-word FIFO onto a valid/ready pixel port.
module frame_buffer_reader #(
    parameter logic [7:0]  customInstructionId = 8'd0,
    parameter int unsigned fifoDepthLog2       = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone,
    output logic        requestBus,
    input  logic        busGrant,
    output logic        beginTransactionOut,
    output logic [31:0] addressDataOut,
    output logic        readNotWriteOut,
    output logic [3:0]  byteEnablesOut,
    output logic [7:0]  burstSizeOut,
    output logic        endTransactionOut,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    input  logic        endTransactionIn,
    input  logic        busErrorIn,
    output logic [31:0] pixelData,
    output logic        pixelValid,
    input  logic        pixelReady,
    output logic        pixelFirst
);
    localparam int unsigned Depth = 1 << fifoDepthLog2;
    localparam int unsigned CntW  = fifoDepthLog2 + 1;
    localparam logic [fifoDepthLog2-1:0] PtrOne = 1;
    localparam logic [CntW-1:0] CntOne = 1;
    localparam logic [CntW-1:0] MinFree = 16;

    typedef enum logic [2:0] {
        IDLE, BETWEEN, REQUEST, INIT, WAIT_DATA
    } state_t;

    state_t state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [8:0]  wpl_q, wpl_d;
    logic [10:0] nol_q, nol_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        frame_done_q, frame_done_d;
    logic        error_q, error_d;
    logic [31:0] addr_q, addr_d;
    logic [8:0]  words_q, words_d;
    logic [10:0] lines_q, lines_d;
    logic [8:0]  wpl_act_q, wpl_act_d;
    logic        first_q, first_d;
    logic [CntW-1:0] count_q, count_d;
    logic [fifoDepthLog2-1:0] wr_ptr_q, wr_ptr_d;
    logic [fifoDepthLog2-1:0] rd_ptr_q, rd_ptr_d;
    logic        request_bus_q, request_bus_d;
    logic        begin_q, begin_d;
    logic [31:0] addr_out_q, addr_out_d;
    logic [7:0]  burst_out_q, burst_out_d;
    logic        end_out_q, end_out_d;
    logic [32:0] mem_q [Depth];

    logic ci_sel, push, pop, bus_state;
    logic [CntW-1:0] free_words;
    logic [7:0] burst_len;
    logic unused_bits;

    assign unused_bits = ^{ciValueA[31:3], ciValueB[31:27], ciValueB[15:9]};

    assign ci_sel = ciStart & ciCke & (ciN == customInstructionId);
    assign ciDone = ci_sel;
    assign pop = (count_q != '0) & pixelReady;
    assign free_words = CntW'(Depth) - count_q;
    assign burst_len = (words_q >= 9'd16) ? 8'd16 : {3'd0, words_q[4:0]};
    assign bus_state = (state_q == REQUEST) || (state_q == INIT)
                    || (state_q == WAIT_DATA);

    always_comb begin
        ciResult = 32'd0;
        if (ci_sel) begin
            case (ciValueA[2:0])
                3'd0:    ciResult = base_q;
                3'd4:    ciResult = {30'd0, error_q, frame_done_q};
                3'd5:    ciResult = {5'd0, lines_q, 7'd0, words_q};
                default: ciResult = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        base_d = base_q;
        wpl_d = wpl_q;
        nol_d = nol_q;
        ctrl_d = ctrl_q;
        frame_done_d = frame_done_q;
        error_d = error_q;
        addr_d = addr_q;
        words_d = words_q;
        lines_d = lines_q;
        wpl_act_d = wpl_act_q;
        first_d = first_q;
        begin_d = 1'b0;
        addr_out_d = 32'd0;
        burst_out_d = 8'd0;
        end_out_d = 1'b0;
        push = 1'b0;

        if (ci_sel) begin
            case (ciValueA[2:0])
                3'd1: base_d = {ciValueB[31:2], 2'b00};
                3'd2: begin
                    wpl_d = ciValueB[8:0];
                    nol_d = ciValueB[26:16];
                end
                3'd3: if (ciValueB[1:0] != 2'b11) ctrl_d = ciValueB[1:0];
                3'd4: begin
                    frame_done_d = 1'b0;
                    error_d = 1'b0;
                end
                default: ;
            endcase
        end

        unique case (state_q)
            IDLE: begin
                if (ctrl_q != 2'b00 && wpl_q != '0 && nol_q != '0) begin
                    addr_d = base_q;
                    words_d = wpl_q;
                    lines_d = nol_q;
                    wpl_act_d = wpl_q;
                    first_d = 1'b1;
                    state_d = BETWEEN;
                end
            end
            BETWEEN: if (free_words >= MinFree) state_d = REQUEST;
            REQUEST: begin
                if (busGrant) begin
                    begin_d = 1'b1;
                    addr_out_d = addr_q;
                    burst_out_d = burst_len - 8'd1;
                    state_d = INIT;
                end
            end
            INIT: state_d = WAIT_DATA;
            WAIT_DATA: begin
                if (dataValidIn && words_q != '0) begin
                    push = 1'b1;
                    addr_d = addr_q + 32'd4;
                    words_d = words_q - 9'd1;
                    first_d = 1'b0;
                end
                if (endTransactionIn) begin
                    if (words_d != '0) begin
                        state_d = BETWEEN;
                    end else if (lines_q <= 11'd1) begin
                        lines_d = 11'd0;
                        frame_done_d = 1'b1;
                        if (ctrl_d == 2'b10) ctrl_d = 2'b00;
                        state_d = IDLE;
                    end else begin
                        lines_d = lines_q - 11'd1;
                        words_d = wpl_act_q;
                        state_d = BETWEEN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort keeps whatever already reached the FIFO.
        if (busErrorIn && bus_state) begin
            state_d = IDLE;
            end_out_d = 1'b1;
            error_d = 1'b1;
            ctrl_d = 2'b00;
            begin_d = 1'b0;
            addr_out_d = 32'd0;
            burst_out_d = 8'd0;
        end

        request_bus_d = (state_d == REQUEST) || (state_d == INIT)
                     || (state_d == WAIT_DATA);
        wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
        count_d = count_q + (push ? CntOne : '0) - (pop ? CntOne : '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            base_q <= 32'd0;
            wpl_q <= 9'd0;
            nol_q <= 11'd0;
            ctrl_q <= 2'b00;
            frame_done_q <= 1'b0;
            error_q <= 1'b0;
            addr_q <= 32'd0;
            words_q <= 9'd0;
            lines_q <= 11'd0;
            wpl_act_q <= 9'd0;
            first_q <= 1'b0;
            count_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            request_bus_q <= 1'b0;
            begin_q <= 1'b0;
            addr_out_q <= 32'd0;
            burst_out_q <= 8'd0;
            end_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q <= base_d;
            wpl_q <= wpl_d;
            nol_q <= nol_d;
            ctrl_q <= ctrl_d;
            frame_done_q <= frame_done_d;
            error_q <= error_d;
            addr_q <= addr_d;
            words_q <= words_d;
            lines_q <= lines_d;
            wpl_act_q <= wpl_act_d;
            first_q <= first_d;
            count_q <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            request_bus_q <= request_bus_d;
            begin_q <= begin_d;
            addr_out_q <= addr_out_d;
            burst_out_q <= burst_out_d;
            end_out_q <= end_out_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) mem_q[wr_ptr_q] <= {first_q, addressDataIn};
    end

    assign requestBus = request_bus_q;
    assign beginTransactionOut = begin_q;
    assign addressDataOut = addr_out_q;
    assign readNotWriteOut = begin_q;
    assign byteEnablesOut = {4{begin_q}};
    assign burstSizeOut = burst_out_q;
    assign endTransactionOut = end_out_q;
    assign pixelValid = (count_q != '0);
    assign pixelData = mem_q[rd_ptr_q][31:0];
    assign pixelFirst = mem_q[rd_ptr_q][32] & pixelValid;
endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader: a bus slave memory model feeds
// bursts while a scoreboard checks every streamed pixel and bus request.
module tb_frame_buffer_reader;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ciStart = 1'b0, ciCke = 1'b0;
    logic [7:0]  ciN = 8'd0;
    logic [31:0] ciValueA = 32'd0, ciValueB = 32'd0;
    logic [31:0] ciResult;
    logic        ciDone;
    logic        requestBus, busGrant;
    logic        beginTransactionOut;
    logic [31:0] addressDataOut;
    logic        readNotWriteOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic        endTransactionOut;
    logic [31:0] addressDataIn = 32'd0;
    logic        dataValidIn = 1'b0, endTransactionIn = 1'b0, busErrorIn = 1'b0;
    logic [31:0] pixelData;
    logic        pixelValid, pixelFirst;
    logic        pixelReady = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  size;
    } burst_t;

    burst_t      bursts_q[$];
    logic [32:0] pix_q[$];
    int checks = 0, passes = 0;
    int bursts_seen = 0, end_cnt = 0, pix_cnt = 0;
    int err_at = -1, short_after = 0;
    bit slave_kill = 1'b0;
    logic [31:0] frame_base = 32'd0;
    logic [31:0] r;
    int b0, e0;
    burst_t      sb_exp;
    logic [31:0] sb_a;
    int          sb_lim;
    logic [32:0] mon_exp;

    frame_buffer_reader dut (
        .clock(clock), .reset(reset),
        .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
        .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciResult(ciResult), .ciDone(ciDone),
        .requestBus(requestBus), .busGrant(busGrant),
        .beginTransactionOut(beginTransactionOut),
        .addressDataOut(addressDataOut),
        .readNotWriteOut(readNotWriteOut),
        .byteEnablesOut(byteEnablesOut),
        .burstSizeOut(burstSizeOut),
        .endTransactionOut(endTransactionOut),
        .addressDataIn(addressDataIn), .dataValidIn(dataValidIn),
        .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn),
        .pixelData(pixelData), .pixelValid(pixelValid),
        .pixelReady(pixelReady), .pixelFirst(pixelFirst)
    );

    always #5 clock = ~clock;
    assign busGrant = requestBus;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ci_wr(input logic [2:0] a, input logic [31:0] b);
        @(posedge clock); #1;
        ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd0;
        ciValueA = {29'd0, a}; ciValueB = b;
        @(posedge clock); #1;
        ciStart = 1'b0; ciCke = 1'b0; ciValueA = 32'd0; ciValueB = 32'd0;
    endtask

    task automatic ci_rd(input logic [2:0] a, output logic [31:0] v);
        @(posedge clock); #1;
        ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd0;
        ciValueA = {29'd0, a}; ciValueB = 32'd0;
        #1 v = ciResult;
        @(posedge clock); #1;
        ciStart = 1'b0; ciCke = 1'b0; ciValueA = 32'd0;
    endtask

    task automatic wait_pix(input int n, input string tag);
        int i;
        i = 0;
        while (pix_cnt < n && i < 3000) begin
            @(negedge clock);
            i++;
        end
        chk(tag, pix_cnt, n);
    endtask

    // Bus slave: checks each burst header, then serves memory words.
    initial begin : slave
        forever begin
            @(negedge clock);
            if (beginTransactionOut) begin
                bursts_seen++;
                sb_a = addressDataOut;
                if (bursts_q.size() == 0) begin
                    chk("burst_unexpected", {32'd0, addressDataOut}, 64'd0);
                end else begin
                    sb_exp = bursts_q.pop_front();
                    chk("burst_addr", addressDataOut, sb_exp.addr);
                    chk("burst_size", burstSizeOut, sb_exp.size);
                end
                chk("burst_rnw", readNotWriteOut, 1);
                chk("burst_be", byteEnablesOut, 4'hF);
                sb_lim = (short_after != 0) ? short_after
                                            : int'(burstSizeOut) + 1;
                short_after = 0;
                for (int k = 0; k < sb_lim; k++) begin
                    @(posedge clock); #1;
                    if (slave_kill) break;
                    if (k == err_at) begin
                        dataValidIn = 1'b0;
                        busErrorIn = 1'b1;
                        err_at = -1;
                        break;
                    end
                    dataValidIn = 1'b1;
                    addressDataIn = mem_word(sb_a);
                    endTransactionIn = (k == sb_lim - 1);
                    pix_q.push_back({sb_a == frame_base, mem_word(sb_a)});
                    sb_a += 32'd4;
                end
                @(posedge clock); #1;
                dataValidIn = 1'b0;
                endTransactionIn = 1'b0;
                busErrorIn = 1'b0;
                addressDataIn = 32'd0;
            end
        end
    end

    always @(negedge clock) begin
        if (endTransactionOut) end_cnt++;
        if (!reset && pixelValid && pixelReady) begin
            if (pix_q.size() == 0) begin
                chk("pixel_unexpected", {31'd0, pixelFirst, pixelData}, 64'd0);
            end else begin
                mon_exp = pix_q.pop_front();
                chk("pixel", {pixelFirst, pixelData}, mon_exp);
            end
            pix_cnt++;
        end
    end

    initial begin : timeout
        #500000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_req", requestBus, 0);
        chk("rst_valid", pixelValid, 0);
        chk("rst_begin", beginTransactionOut, 0);
        chk("rst_addr", addressDataOut, 0);
        ci_rd(3'd4, r);
        chk("rst_status", r, 0);
        ci_rd(3'd0, r);
        chk("rst_base", r, 0);
        chk("ci_unselected", ciResult, 0);

        // 20 words x 2 lines, single frame, consumer always ready
        frame_base = 32'h1000;
        pixelReady = 1'b1;
        ci_wr(3'd1, 32'h0000_1003);
        ci_rd(3'd0, r);
        chk("base_align", r, 32'h1000);
        ci_wr(3'd2, {5'd0, 11'd2, 7'd0, 9'd20});
        bursts_q.push_back('{addr: 32'h1000, size: 8'd15});
        bursts_q.push_back('{addr: 32'h1040, size: 8'd3});
        bursts_q.push_back('{addr: 32'h1050, size: 8'd15});
        bursts_q.push_back('{addr: 32'h1090, size: 8'd3});
        pix_cnt = 0;
        ci_wr(3'd3, 32'd2);
        wait_pix(40, "a_count");
        repeat (5) @(negedge clock);
        chk("a_bursts_left", bursts_q.size(), 0);
        chk("a_no_end_out", end_cnt, 0);
        ci_rd(3'd5, r);
        chk("a_fetch_ptr", r, 0);
        ci_rd(3'd4, r);
        chk("a_status", r, 1);
        ci_rd(3'd4, r);
        chk("a_status_clr", r, 0);

        // same frame, consumer stalled: admission rule holds third burst
        pixelReady = 1'b0;
        bursts_q.push_back('{addr: 32'h1000, size: 8'd15});
        bursts_q.push_back('{addr: 32'h1040, size: 8'd3});
        bursts_q.push_back('{addr: 32'h1050, size: 8'd15});
        bursts_q.push_back('{addr: 32'h1090, size: 8'd3});
        pix_cnt = 0;
        b0 = bursts_seen;
        ci_wr(3'd3, 32'd2);
        repeat (200) @(negedge clock);
        chk("b_stall_bursts", bursts_seen - b0, 2);
        chk("b_valid_held", pixelValid, 1);
        ci_rd(3'd5, r);
        chk("b_fetch_ptr", r, 32'h0001_0014);
        pixelReady = 1'b1;
        wait_pix(40, "b_count");
        repeat (5) @(negedge clock);
        chk("b_bursts_left", bursts_q.size(), 0);
        ci_rd(3'd4, r);
        chk("b_status", r, 1);

        // bus error on third word of first burst
        err_at = 2;
        bursts_q.push_back('{addr: 32'h1000, size: 8'd15});
        pix_cnt = 0;
        e0 = end_cnt;
        b0 = bursts_seen;
        ci_wr(3'd3, 32'd2);
        wait_pix(2, "c_count");
        repeat (30) @(negedge clock);
        chk("c_end_pulse", end_cnt - e0, 1);
        chk("c_one_burst", bursts_seen - b0, 1);
        chk("c_req_idle", requestBus, 0);
        ci_rd(3'd4, r);
        chk("c_status_err", r, 2);
        ci_rd(3'd4, r);
        chk("c_status_clr", r, 0);

        // continuous 4x1 frames, then stop mid-frame
        frame_base = 32'h2000;
        ci_wr(3'd1, 32'h2000);
        ci_wr(3'd2, {5'd0, 11'd1, 7'd0, 9'd4});
        bursts_q.push_back('{addr: 32'h2000, size: 8'd3});
        bursts_q.push_back('{addr: 32'h2000, size: 8'd3});
        pix_cnt = 0;
        b0 = bursts_seen;
        ci_wr(3'd3, 32'd1);
        for (int i = 0; i < 500 && bursts_seen - b0 < 2; i++)
            @(negedge clock);
        ci_wr(3'd3, 32'd0);
        repeat (60) @(negedge clock);
        chk("d_bursts", bursts_seen - b0, 2);
        chk("d_count", pix_cnt, 8);
        chk("d_req_idle", requestBus, 0);
        ci_rd(3'd4, r);
        chk("d_status", r, 1);

        // slave ends first burst after 10 of 16 words
        frame_base = 32'h3000;
        ci_wr(3'd1, 32'h3000);
        ci_wr(3'd2, {5'd0, 11'd1, 7'd0, 9'd16});
        short_after = 10;
        bursts_q.push_back('{addr: 32'h3000, size: 8'd15});
        bursts_q.push_back('{addr: 32'h3028, size: 8'd5});
        pix_cnt = 0;
        ci_wr(3'd3, 32'd2);
        wait_pix(16, "e_count");
        repeat (5) @(negedge clock);
        chk("e_bursts_left", bursts_q.size(), 0);
        ci_rd(3'd4, r);
        chk("e_status", r, 1);

        // reset while data is streaming
        frame_base = 32'h4000;
        ci_wr(3'd1, 32'h4000);
        ci_wr(3'd2, {5'd0, 11'd1, 7'd0, 9'd16});
        bursts_q.push_back('{addr: 32'h4000, size: 8'd15});
        b0 = bursts_seen;
        ci_wr(3'd3, 32'd2);
        for (int i = 0; i < 500 && bursts_seen == b0; i++)
            @(negedge clock);
        repeat (3) @(negedge clock);
        slave_kill = 1'b1;
        e0 = end_cnt;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("f_req", requestBus, 0);
        chk("f_begin", beginTransactionOut, 0);
        chk("f_end", endTransactionOut, 0);
        chk("f_valid", pixelValid, 0);
        chk("f_burst_size", burstSizeOut, 0);
        pix_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (10) @(negedge clock);
        slave_kill = 1'b0;
        chk("f_no_end_out", end_cnt - e0, 0);
        chk("f_no_restart", requestBus, 0);
        ci_rd(3'd4, r);
        chk("f_status", r, 0);
        ci_rd(3'd0, r);
        chk("f_base", r, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
